switch_debounce: RTL

Per-bit input conditioner that sits between the MCPNR_SWITCHES bank and downstream logic such as the multibit NOR test datapath.
- Synchronises raw switch levels into CLK with a 2-flop chain.
- Filters each bit so that a level change only propagates after it has been stable for STABLE_CYCLES clocks.
- Emits one-cycle rise/fall/changed pulses for consumers that need edge events.
- Output O is a drop-in replacement for the raw switch bus; for example, {a, b} = O with WIDTH=16.

---
 rtl/switch_debounce.sv | 90 +++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser followed by a per-bit stability filter.
// O follows a synchronised level only after it has differed from O for STABLE_CYCLES clocks.
module switch_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            s1_r;
    logic [WIDTH-1:0]            s2_r;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0]            o_r;
    logic [WIDTH-1:0]            rise_r;
    logic [WIDTH-1:0]            fall_r;
    logic                        changed_r;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_next_s;
    logic [WIDTH-1:0]            o_next_s;
    logic [WIDTH-1:0]            rise_next_s;
    logic [WIDTH-1:0]            fall_next_s;
    logic                        changed_next_s;

    // Two-stage synchroniser; only s2_r is allowed to reach the filter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= I;
            s2_r <= s1_r;
        end
    end

    // Per-bit filter: count consecutive mismatches, commit the new level on the last one.
    always_comb begin
        cnt_next_s  = {WIDTH{CNT_ZERO}};
        o_next_s    = o_r;
        rise_next_s = {WIDTH{1'b0}};
        fall_next_s = {WIDTH{1'b0}};
        for (int b = 0; b < WIDTH; b++) begin
            if (s2_r[b] == o_r[b]) begin
                cnt_next_s[b] = CNT_ZERO;
            end else if (cnt_r[b] != CNT_LAST) begin
                cnt_next_s[b] = cnt_r[b] + CNT_ONE;
            end else begin
                // Counter clears on commit, so it never exceeds CNT_LAST.
                cnt_next_s[b]  = CNT_ZERO;
                o_next_s[b]    = s2_r[b];
                rise_next_s[b] = s2_r[b];
                fall_next_s[b] = ~s2_r[b];
            end
        end
        changed_next_s = |(rise_next_s | fall_next_s);
    end

    // Filter state and registered outputs; pulses are rebuilt every cycle so they last one clock.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_r     <= {WIDTH{CNT_ZERO}};
            o_r       <= {WIDTH{1'b0}};
            rise_r    <= {WIDTH{1'b0}};
            fall_r    <= {WIDTH{1'b0}};
            changed_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            o_r       <= o_next_s;
            rise_r    <= rise_next_s;
            fall_r    <= fall_next_s;
            changed_r <= changed_next_s;
        end
    end

    assign O       = o_r;
    assign RISE    = rise_r;
    assign FALL    = fall_r;
    assign CHANGED = changed_r;

endmodule
